// File: rtl/adc_sample_sequencer.sv
`timescale 1ns/1ps
// adc_sample_sequencer: round-robin ADC channel scanner that tags each
// result and writes it to a FIFO without ever stalling on backpressure.
module adc_sample_sequencer #(
    parameter  int NUM_CHANNELS = 4,
    parameter  int SAMPLE_WIDTH = 12,
    parameter  int CONV_TIMEOUT = 255,
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CHANNELS-1:0] channel_mask,
    input  logic [15:0]             scan_period,
    output logic                    adc_start,
    output logic [CH_W-1:0]         adc_channel,
    input  logic                    adc_done,
    input  logic [SAMPLE_WIDTH-1:0] adc_data,
    output logic                    write_enable,
    output logic [31:0]             write_data,
    input  logic                    write_ready,
    output logic                    busy,
    output logic                    scan_done,
    output logic                    timeout_error,
    output logic [15:0]             sample_count,
    output logic [15:0]             drop_count
);

    localparam int TMO_W = (CONV_TIMEOUT > 1) ? $clog2(CONV_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CONV_TIMEOUT - 1);
    localparam logic [CH_W-1:0]  LAST_IDX = CH_W'(NUM_CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_START,
        S_CONVERT,
        S_WRITE,
        S_NEXT,
        S_WAIT
    } state_e;

    state_e                  state_q, state_d;
    logic [CH_W-1:0]         idx_q, idx_d;
    logic [NUM_CHANNELS-1:0] mask_q, mask_d;
    logic [11:0]             seq_q, seq_d;
    logic [15:0]             period_q, period_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    adc_start_q, adc_start_d;
    logic [CH_W-1:0]         adc_channel_q, adc_channel_d;
    logic [31:0]             write_data_q, write_data_d;
    logic                    scan_done_q, scan_done_d;
    logic                    timeout_error_q, timeout_error_d;
    logic [15:0]             sample_count_q, sample_count_d;
    logic [15:0]             drop_count_q, drop_count_d;

    logic        can_start;
    logic [16:0] period_next;
    logic        period_elapsed;
    logic [3:0]  ch_tag;

    assign can_start      = enable && (|channel_mask);
    assign period_next    = {1'b0, period_q} + 17'd1;
    // Compare against the count after this cycle so the start-to-start
    // interval equals scan_period exactly.
    assign period_elapsed = period_next >= {1'b0, scan_period};
    assign ch_tag         = 4'(idx_q);

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        mask_d          = mask_q;
        seq_d           = seq_q;
        period_d        = period_q;
        tmo_d           = tmo_q;
        adc_start_d     = 1'b0;
        adc_channel_d   = adc_channel_q;
        write_data_d    = write_data_q;
        scan_done_d     = 1'b0;
        timeout_error_d = 1'b0;
        sample_count_d  = sample_count_q;
        drop_count_d    = drop_count_q;

        if (state_q != S_IDLE && period_q != 16'hFFFF) begin
            period_d = period_q + 16'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (can_start) begin
                    mask_d   = channel_mask;
                    idx_d    = '0;
                    period_d = '0;
                    state_d  = S_SELECT;
                end
            end
            S_SELECT: begin
                if (mask_q[idx_q]) begin
                    adc_start_d   = 1'b1;
                    adc_channel_d = idx_q;
                    tmo_d         = '0;
                    state_d       = S_START;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_START: begin
                state_d = S_CONVERT;
            end
            S_CONVERT: begin
                if (adc_done) begin
                    write_data_d = {ch_tag, seq_q, 16'(adc_data)};
                    state_d      = S_WRITE;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_error_d = 1'b1;
                    state_d         = S_NEXT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (write_ready) begin
                    if (sample_count_q != 16'hFFFF) begin
                        sample_count_d = sample_count_q + 16'd1;
                    end
                end else if (drop_count_q != 16'hFFFF) begin
                    drop_count_d = drop_count_q + 16'd1;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    scan_done_d = 1'b1;
                    seq_d       = seq_q + 12'd1;
                    state_d     = S_WAIT;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_SELECT;
                end
            end
            S_WAIT: begin
                if (period_elapsed) begin
                    if (can_start) begin
                        mask_d   = channel_mask;
                        idx_d    = '0;
                        period_d = '0;
                        state_d  = S_SELECT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            mask_q          <= '0;
            seq_q           <= '0;
            period_q        <= '0;
            tmo_q           <= '0;
            adc_start_q     <= 1'b0;
            adc_channel_q   <= '0;
            write_data_q    <= '0;
            scan_done_q     <= 1'b0;
            timeout_error_q <= 1'b0;
            sample_count_q  <= '0;
            drop_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            mask_q          <= mask_d;
            seq_q           <= seq_d;
            period_q        <= period_d;
            tmo_q           <= tmo_d;
            adc_start_q     <= adc_start_d;
            adc_channel_q   <= adc_channel_d;
            write_data_q    <= write_data_d;
            scan_done_q     <= scan_done_d;
            timeout_error_q <= timeout_error_d;
            sample_count_q  <= sample_count_d;
            drop_count_q    <= drop_count_d;
        end
    end

    // The write strobe follows write_ready in the same cycle, so the FIFO
    // is never written while full.
    assign write_enable  = (state_q == S_WRITE) && write_ready;
    assign write_data    = write_data_q;
    assign adc_start     = adc_start_q;
    assign adc_channel   = adc_channel_q;
    assign busy          = (state_q != S_IDLE);
    assign scan_done     = scan_done_q;
    assign timeout_error = timeout_error_q;
    assign sample_count  = sample_count_q;
    assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
`timescale 1ns/1ps
// Directed bench for adc_sample_sequencer with a behavioural ADC front end
// and a negedge monitor that logs writes, starts and pulses.
module tb_adc_sample_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  channel_mask;
    logic [15:0] scan_period;
    logic        adc_start;
    logic [1:0]  adc_channel;
    logic        adc_done;
    logic [11:0] adc_data;
    logic        write_enable;
    logic [31:0] write_data;
    logic        write_ready;
    logic        busy;
    logic        scan_done;
    logic        timeout_error;
    logic [15:0] sample_count;
    logic [15:0] drop_count;

    logic wr_ok;
    logic blk2;
    assign write_ready = wr_ok & ~(blk2 & (adc_channel == 2'd2));

    adc_sample_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .channel_mask  (channel_mask),
        .scan_period   (scan_period),
        .adc_start     (adc_start),
        .adc_channel   (adc_channel),
        .adc_done      (adc_done),
        .adc_data      (adc_data),
        .write_enable  (write_enable),
        .write_data    (write_data),
        .write_ready   (write_ready),
        .busy          (busy),
        .scan_done     (scan_done),
        .timeout_error (timeout_error),
        .sample_count  (sample_count),
        .drop_count    (drop_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [31:0] wq[$];
    int          st_cyc[$];
    int          st_ch[$];
    int          sd_cyc[$];
    int          to_cyc[$];
    int          viol = 0;

    always @(negedge clock) begin
        if (write_enable === 1'b1) wq.push_back(write_data);
        if (write_enable === 1'b1 && write_ready !== 1'b1) viol++;
        if (adc_start === 1'b1) begin
            st_cyc.push_back(cyc);
            st_ch.push_back(int'(adc_channel));
        end
        if (scan_done === 1'b1) sd_cyc.push_back(cyc);
        if (timeout_error === 1'b1) to_cyc.push_back(cyc);
    end

    // ADC front end: answers a start after `delay` CONVERT cycles.
    int          delay = 5;
    logic [11:0] tbl[4];
    logic        noresp[4];

    initial begin
        adc_done = 1'b0;
        adc_data = '0;
        forever begin
            @(negedge clock);
            if (adc_start === 1'b1 && !noresp[adc_channel]) begin
                automatic int ch = int'(adc_channel);
                @(posedge clock);
                repeat (delay - 1) @(posedge clock);
                #1;
                adc_done = 1'b1;
                adc_data = tbl[ch];
                @(posedge clock);
                #1;
                adc_done = 1'b0;
                adc_data = '0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int base;
        reset        = 1'b1;
        enable       = 1'b0;
        channel_mask = '0;
        scan_period  = '0;
        wr_ok        = 1'b1;
        blk2         = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tbl[i]    = '0;
            noresp[i] = 1'b0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_adc_start", 32'(adc_start), 0);
        chk("rst_write_enable", 32'(write_enable), 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_counts", {sample_count, drop_count}, 0);
        chk("rst_pulses", {30'd0, scan_done, timeout_error}, 0);
        reset = 1'b0;

        // Normal scan, mask 0101, period 100
        tbl[0]       = 12'hABC;
        tbl[2]       = 12'h123;
        delay        = 5;
        channel_mask = 4'b0101;
        scan_period  = 16'd100;
        enable       = 1'b1;
        n = 0;
        while (wq.size() < 3 && n < 300) begin
            @(posedge clock);
            n++;
        end
        chk("p1_wait_writes", 32'(wq.size() >= 3), 1);
        @(negedge clock);
        chk("p1_word0", wq[0], 32'h00000ABC);
        chk("p1_word1", wq[1], 32'h20000123);
        chk("p1_word2", wq[2], 32'h00010ABC);
        chk("p1_sample_count", 32'(sample_count), 3);
        chk("p1_scan_interval", 32'(st_cyc[2] - st_cyc[0]), 100);
        chk("p1_scan_done_time", 32'(sd_cyc[0] - st_cyc[0]), 21);

        // Backpressure on the ch2 write of the second scan
        blk2 = 1'b1;
        n = 0;
        while (drop_count != 16'd1 && n < 100) begin
            @(posedge clock);
            n++;
        end
        @(negedge clock);
        chk("p2_drop_count", 32'(drop_count), 1);
        chk("p2_sample_count", 32'(sample_count), 3);
        chk("p2_no_write", 32'(wq.size()), 3);
        n = 0;
        while (sd_cyc.size() < 2 && n < 100) begin
            @(posedge clock);
            n++;
        end
        chk("p2_scan_done_time", 32'(sd_cyc[1] - st_cyc[2]), 21);
        @(negedge clock);
        blk2   = 1'b0;
        enable = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clock);
            n++;
        end
        chk("p2_idle", 32'(busy), 0);

        // Timeout on ch1, ch2 converts normally
        @(negedge clock);
        noresp[1]    = 1'b1;
        channel_mask = 4'b0110;
        enable       = 1'b1;
        n = 0;
        while (to_cyc.size() < 1 && n < 400) begin
            @(posedge clock);
            n++;
        end
        @(negedge clock);
        enable = 1'b0;
        n = 0;
        while (sd_cyc.size() < 3 && n < 100) begin
            @(posedge clock);
            n++;
        end
        @(negedge clock);
        chk("p3_timeout_pulses", 32'(to_cyc.size()), 1);
        chk("p3_timeout_ch", 32'(st_ch[4]), 1);
        chk("p3_timeout_time", 32'(to_cyc[0] - st_cyc[4]), 256);
        chk("p3_writes", 32'(wq.size()), 4);
        chk("p3_word_ch2", wq[3], 32'h20020123);
        chk("p3_sample_count", 32'(sample_count), 4);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clock);
            n++;
        end

        // Enable drop during ch0 CONVERT, mask 1111
        @(negedge clock);
        noresp[1]    = 1'b0;
        tbl[0]       = 12'h111;
        tbl[1]       = 12'h222;
        tbl[3]       = 12'h444;
        channel_mask = 4'b1111;
        enable       = 1'b1;
        n = 0;
        while (st_cyc.size() < 7 && n < 20) begin
            @(posedge clock);
            n++;
        end
        @(negedge clock);
        enable = 1'b0;
        n = 0;
        while (sd_cyc.size() < 4 && n < 200) begin
            @(posedge clock);
            n++;
        end
        n = 0;
        while (busy && n < 200) begin
            @(posedge clock);
            n++;
        end
        repeat (30) @(negedge clock);
        chk("p4_writes", 32'(wq.size()), 8);
        chk("p4_word_ch0", wq[4], 32'h00030111);
        chk("p4_word_ch1", wq[5], 32'h10030222);
        chk("p4_word_ch2", wq[6], 32'h20030123);
        chk("p4_word_ch3", wq[7], 32'h30030444);
        chk("p4_scan_done", 32'(sd_cyc.size()), 4);
        chk("p4_busy", 32'(busy), 0);
        chk("p4_no_more_starts", 32'(st_cyc.size()), 10);

        // Reset pulsed during CONVERT, late adc_done arrives afterwards
        tbl[0]       = 12'h777;
        channel_mask = 4'b0001;
        enable       = 1'b1;
        n = 0;
        while (st_cyc.size() < 11 && n < 20) begin
            @(posedge clock);
            n++;
        end
        @(negedge clock);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (12) @(negedge clock);
        chk("p5_busy", 32'(busy), 0);
        chk("p5_outputs", {29'd0, adc_start, scan_done, timeout_error}, 0);
        chk("p5_channel", 32'(adc_channel), 0);
        chk("p5_write_data", write_data, 0);
        chk("p5_counts", {sample_count, drop_count}, 0);
        chk("p5_no_write", 32'(wq.size()), 8);

        // Back-to-back scans, sample_count saturation, sequence wrap
        tbl[0]       = 12'hABC;
        delay        = 1;
        scan_period  = 16'd0;
        channel_mask = 4'b0001;
        enable       = 1'b1;
        base         = wq.size();
        n = 0;
        while (st_cyc.size() < 13 && n < 100) begin
            @(posedge clock);
            n++;
        end
        chk("p6_b2b_interval", 32'(st_cyc[12] - st_cyc[11]), 12);
        @(negedge clock);
        force dut.sample_count_q = 16'hFFFE;
        @(negedge clock);
        release dut.sample_count_q;
        n = 0;
        while (wq.size() < base + 4097 && n < 60000) begin
            @(posedge clock);
            n++;
        end
        @(negedge clock);
        chk("p6_wait_wrap", 32'(wq.size() >= base + 4097), 1);
        chk("p6_seq_1", wq[base + 1], 32'h00010ABC);
        chk("p6_seq_fff", wq[base + 4095], 32'h0FFF0ABC);
        chk("p6_seq_wrap", wq[base + 4096], 32'h00000ABC);
        chk("p6_sample_sat", 32'(sample_count), 32'h0000FFFF);
        chk("p6_drop_count", 32'(drop_count), 0);
        enable = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            @(posedge clock);
            n++;
        end
        chk("p6_idle", 32'(busy), 0);
        chk("write_while_full", 32'(viol), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
